// File: rtl/multi_vib_sched.sv
// multi_vib_sched: round-robin scheduler sharing one monostable pulse generator among N triggers.
// Define MVS_RETRIGGER_EN to make the owner's rise during its pulse reload the width counter.
module multi_vib_sched #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int GAP = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sig,
    input  logic [W-1:0]         pw,
    output logic                 out,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic [N-1:0]         pending,
    output logic                 miss
);
    localparam int IW = $clog2(N);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_sig_q, r_grant, r_pending;
    logic [IW-1:0] r_ptr, r_gnt_id;
    logic [W-1:0]  r_cnt;
    logic [GW-1:0] r_gcnt;
    logic          r_out, r_busy, r_miss;

    logic [N-1:0]  w_rise, w_req, w_cand;
    logic [IW-1:0] w_win;
    logic [W-1:0]  w_cnt_ld;
    logic          w_retrig, w_arb, w_found;

    assign w_rise = sig & ~r_sig_q;
`ifdef MVS_RETRIGGER_EN
    assign w_retrig = (r_state == S_PULSE) && w_rise[r_gnt_id];
`else
    assign w_retrig = 1'b0;
`endif
    // the owner's rise that retriggers is consumed here and never reaches the queue
    assign w_req    = w_rise & ~(w_retrig ? r_grant : '0);
    assign w_cand   = r_pending | w_req;
    assign w_cnt_ld = (pw == '0) ? '0 : pw - 1'b1;
    assign w_arb    = (r_state == S_IDLE) || (r_state == S_GAP && r_gcnt == '0) ||
                      (GAP == 0 && r_state == S_PULSE && r_cnt == '0 && !w_retrig);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_cand[(int'(r_ptr) + j) % N]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_ptr) + j) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sig_q   <= '0;
            r_grant   <= '0;
            r_pending <= '0;
            r_ptr     <= '0;
            r_gnt_id  <= '0;
            r_cnt     <= '0;
            r_gcnt    <= '0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_miss    <= 1'b0;
        end else begin
            r_sig_q   <= sig;
            r_miss    <= |(w_req & r_pending);
            r_pending <= w_cand;
            if (w_arb && w_found) begin
                r_state   <= S_PULSE;
                r_out     <= 1'b1;
                r_busy    <= 1'b1;
                r_grant   <= N'(1) << w_win;
                r_gnt_id  <= w_win;
                r_pending <= w_cand & ~(N'(1) << w_win);
                r_cnt     <= w_cnt_ld;
                r_ptr     <= (w_win == IW'(N - 1)) ? '0 : w_win + 1'b1;
            end else if (w_arb) begin
                r_state <= S_IDLE;
                r_out   <= 1'b0;
                r_busy  <= 1'b0;
                r_grant <= '0;
            end else if (r_state == S_PULSE) begin
                if (w_retrig)
                    r_cnt <= w_cnt_ld;
                else if (r_cnt == '0) begin
                    r_state <= S_GAP;
                    r_out   <= 1'b0;
                    r_grant <= '0;
                    r_gcnt  <= GW'(GAP - 1);
                end else
                    r_cnt <= r_cnt - 1'b1;
            end else
                r_gcnt <= r_gcnt - 1'b1;
        end
    end

    assign out     = r_out;
    assign grant   = r_grant;
    assign gnt_id  = r_gnt_id;
    assign busy    = r_busy;
    assign pending = r_pending;
    assign miss    = r_miss;
endmodule

// File: tb/tb_multi_vib_sched.sv
// tb_multi_vib_sched: directed vectors for the shared-pulse scheduler (GAP=2 and GAP=0 instances).
module tb_multi_vib_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig, sig0;
    logic [7:0] pw, pw0;
    logic       out, busy, miss, out0, busy0, miss0;
    logic [3:0] grant, pending, grant0, pending0;
    logic [1:0] gnt_id, gnt_id0;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    multi_vib_sched #(.N(4), .W(8), .GAP(2)) u_dut (
        .clk(clk), .rst(rst), .sig(sig), .pw(pw), .out(out), .grant(grant),
        .gnt_id(gnt_id), .busy(busy), .pending(pending), .miss(miss)
    );

    multi_vib_sched #(.N(4), .W(8), .GAP(0)) u_gz (
        .clk(clk), .rst(rst), .sig(sig0), .pw(pw0), .out(out0), .grant(grant0),
        .gnt_id(gnt_id0), .busy(busy0), .pending(pending0), .miss(miss0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_o(input string tag, input logic o, input logic [3:0] g, input logic b);
        chk({tag, ".out"}, 32'(out), 32'(o));
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; sig = 4'b0001; pw = 8'd3; sig0 = '0; pw0 = '0;
        // sig held high through reset fires at the first edge after release
        tick; expect_o("rst1", 0, 4'h0, 0);
        chk("rst1.pending", 32'(pending), 32'h0);
        chk("rst1.miss", 32'(miss), 32'h0);
        chk("rst1.gnt_id", 32'(gnt_id), 32'h0);
        tick; expect_o("rst2", 0, 4'h0, 0);
        rst = 1'b0;
        tick; expect_o("rel.e1", 1, 4'h1, 1);
        tick; tick; expect_o("rel.e3", 1, 4'h1, 1);
        tick; expect_o("rel.e4", 0, 4'h0, 1);
        tick; expect_o("rel.e5", 0, 4'h0, 1);
        tick; expect_o("rel.e6", 0, 4'h0, 0);
        sig = '0; tick;
        // single trigger on ch2
        sig = 4'b0100;
        tick; expect_o("one.e1", 1, 4'h4, 1);
        chk("one.gnt_id", 32'(gnt_id), 32'h2);
        tick; tick; expect_o("one.e3", 1, 4'h4, 1);
        tick; expect_o("one.e4", 0, 4'h0, 1);
        tick; expect_o("one.e5", 0, 4'h0, 1);
        tick; expect_o("one.e6", 0, 4'h0, 0);
        chk("one.gnt_hold", 32'(gnt_id), 32'h2);
        sig = '0; rst = 1'b1; tick;
        rst = 1'b0; tick; expect_o("rst3", 0, 4'h0, 0);
        // simultaneous rises with ptr=0
        sig = 4'b1011;
        tick; expect_o("sim.e1", 1, 4'h1, 1);
        chk("sim.e1.pending", 32'(pending), 32'hA);
        repeat (5) tick; expect_o("sim.e6", 1, 4'h2, 1);
        chk("sim.e6.pending", 32'(pending), 32'h8);
        repeat (5) tick; expect_o("sim.e11", 1, 4'h8, 1);
        chk("sim.e11.pending", 32'(pending), 32'h0);
        chk("sim.e11.gnt_id", 32'(gnt_id), 32'h3);
        repeat (5) tick; expect_o("sim.e16", 0, 4'h0, 0);
        sig = '0; tick;
        // repeated rise on an already-pending channel
        sig = 4'b0001; tick; expect_o("drop.e1", 1, 4'h1, 1);
        sig = 4'b0011; tick;
        chk("drop.e2.pending", 32'(pending), 32'h2);
        chk("drop.e2.miss", 32'(miss), 32'h0);
        sig = 4'b0001; tick;
        sig = 4'b0011; tick;
        chk("drop.e4.miss", 32'(miss), 32'h1);
        chk("drop.e4.pending", 32'(pending), 32'h2);
        sig = 4'b0001; tick;
        chk("drop.e5.miss", 32'(miss), 32'h0);
        tick; expect_o("drop.e6", 1, 4'h2, 1);
        chk("drop.e6.pending", 32'(pending), 32'h0);
        repeat (5) tick; expect_o("drop.e11", 0, 4'h0, 0);
        sig = '0; tick;
        // owner re-rises while its pulse is running
        sig = 4'b0100; tick; expect_o("own.e1", 1, 4'h4, 1);
        sig = '0; tick;
        sig = 4'b0100; tick;
        chk("own.e3.out", 32'(out), 32'h1);
        chk("own.e3.miss", 32'(miss), 32'h0);
`ifdef MVS_RETRIGGER_EN
        chk("own.e3.pending", 32'(pending), 32'h0);
        tick; expect_o("own.e4", 1, 4'h4, 1);
        tick; expect_o("own.e5", 1, 4'h4, 1);
        tick; expect_o("own.e6", 0, 4'h0, 1);
`else
        chk("own.e3.pending", 32'(pending), 32'h4);
        tick; expect_o("own.e4", 0, 4'h0, 1);
        tick; expect_o("own.e5", 0, 4'h0, 1);
        tick; expect_o("own.e6", 1, 4'h4, 1);
        chk("own.e6.pending", 32'(pending), 32'h0);
`endif
        repeat (5) tick; expect_o("own.e11", 0, 4'h0, 0);
        sig = '0;
        // GAP=0, pw=0: back-to-back single-cycle pulses
        sig0 = 4'b0011; tick;
        chk("gz.e1.out", 32'(out0), 32'h1);
        chk("gz.e1.grant", 32'(grant0), 32'h1);
        chk("gz.e1.pending", 32'(pending0), 32'h2);
        tick;
        chk("gz.e2.out", 32'(out0), 32'h1);
        chk("gz.e2.grant", 32'(grant0), 32'h2);
        tick;
        chk("gz.e3.out", 32'(out0), 32'h0);
        chk("gz.e3.grant", 32'(grant0), 32'h0);
        chk("gz.e3.busy", 32'(busy0), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
